// File: rtl/usb_wb_init_pkg.sv
// Shared types and widths for the USB register-bus Wishbone initiator.
package usb_wb_init_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;
   localparam int CMD_W  = 1 + ADDR_W + DATA_W;
   localparam int TMR_W  = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } wbState_t;

   // One queued register access: direction, address and write data.
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wbCmd_t;

endpackage

// File: rtl/usb_wb_cmd_fifo.sv
// Command FIFO: power-of-two depth, first-word-fall-through read port.
module usb_wb_cmd_fifo
   import usb_wb_init_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             pushEn,
   input  logic [CMD_W-1:0] pushData,
   input  logic             popEn,
   output logic [CMD_W-1:0] popData,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [CMD_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W:0]   count;
   logic             doPush;
   logic             doPop;

   assign full    = (count == (PTR_W + 1)'(DEPTH));
   assign empty   = (count == '0);
   assign doPush  = pushEn && !full;
   assign doPop   = popEn && !empty;
   assign popData = mem[rdPtr];

   // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         // NOTE: state updates use <= so every flop samples pre-edge values, independent of statement order.
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Entry storage.
   // NOTE: the array is deliberately not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk_i) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

endmodule

// File: rtl/usb_wb_initiator.sv
// Queues register commands and executes them one at a time as Wishbone
// cycles towards the USB core, returning read data or a timeout flag.
module usb_wb_initiator
   import usb_wb_init_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 255
)
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_we_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_data_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              rsp_err_o,
   output logic [ADDR_W-1:0] address_o,
   output logic [DATA_W-1:0] data_o,
   output logic              we_o,
   output logic              strobe_o,
   input  logic [DATA_W-1:0] data_i,
   input  logic              ack_i,
   output logic              busy_o
);

   // Last counter value before the cycle that times out.
   localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   wbState_t          state;
   wbState_t          stateNext;
   wbCmd_t            headCmd;
   logic [CMD_W-1:0]  fifoData;
   logic              fifoFull;
   logic              fifoEmpty;
   logic              fifoPop;
   logic [TMR_W-1:0]  tmrCnt;
   logic [TMR_W-1:0]  tmrNext;
   logic [ADDR_W-1:0] addrNext;
   logic [DATA_W-1:0] dataNext;
   logic              weNext;
   logic              strobeNext;
   logic              rspValidNext;
   logic              rspErrNext;
   logic [DATA_W-1:0] rspDataNext;

   assign headCmd     = wbCmd_t'(fifoData);
   assign cmd_ready_o = !fifoFull;
   assign busy_o      = (state != IDLE) || !fifoEmpty;

   usb_wb_cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) cmdFifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .pushEn   (cmd_valid_i),
      .pushData ({cmd_we_i, cmd_addr_i, cmd_data_i}),
      .popEn    (fifoPop),
      .popData  (fifoData),
      .full     (fifoFull),
      .empty    (fifoEmpty)
   );

   // State register plus the registered bus and response outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         tmrCnt      <= '0;
         address_o   <= '0;
         data_o      <= '0;
         we_o        <= 1'b0;
         strobe_o    <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;
         rsp_data_o  <= '0;
      end else begin
         state       <= stateNext;
         tmrCnt      <= tmrNext;
         address_o   <= addrNext;
         data_o      <= dataNext;
         we_o        <= weNext;
         strobe_o    <= strobeNext;
         rsp_valid_o <= rspValidNext;
         rsp_err_o   <= rspErrNext;
         rsp_data_o  <= rspDataNext;
      end
   end

   // Next-state decode: launch, terminate (ack beats timeout), hand back.
   always_comb begin
      // NOTE: every target takes a hold default first, so no branch can leave a signal unassigned and infer a latch.
      stateNext    = state;
      tmrNext      = tmrCnt;
      addrNext     = address_o;
      dataNext     = data_o;
      weNext       = we_o;
      strobeNext   = strobe_o;
      rspValidNext = rsp_valid_o;
      rspErrNext   = rsp_err_o;
      rspDataNext  = rsp_data_o;
      fifoPop      = 1'b0;
      case (state)
         IDLE: begin
            if (!fifoEmpty) begin
               fifoPop    = 1'b1;
               addrNext   = headCmd.addr;
               dataNext   = headCmd.data;
               weNext     = headCmd.we;
               strobeNext = 1'b1;
               tmrNext    = '0;
               stateNext  = BUS;
            end
         end
         BUS: begin
            if (ack_i) begin
               strobeNext   = 1'b0;
               rspDataNext  = we_o ? '0 : data_i;
               rspErrNext   = 1'b0;
               rspValidNext = 1'b1;
               stateNext    = RESP;
            end else if (tmrCnt == TIMEOUT_LAST) begin
               strobeNext   = 1'b0;
               rspDataNext  = '0;
               rspErrNext   = 1'b1;
               rspValidNext = 1'b1;
               stateNext    = RESP;
            end else begin
               tmrNext = tmrCnt + 1'b1;
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               rspValidNext = 1'b0;
               stateNext    = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

endmodule

// File: tb/tb_usb_wb_initiator.sv
// Scoreboard bench for usb_wb_initiator: a driver records accepted commands,
// a Wishbone slave model consumes them and predicts each response, and a
// response monitor compares what the DUT hands back.
module tb_usb_wb_initiator;

   localparam int TMO   = 8;
   localparam int DEPTH = 4;

   typedef struct {
      logic       we;
      logic [7:0] addr;
      logic [7:0] data;
   } cmdT;

   typedef struct {
      logic       err;
      logic [7:0] data;
   } rspT;

   logic       clk;
   logic       rst_i;
   logic       cmd_valid_i;
   logic       cmd_ready_o;
   logic       cmd_we_i;
   logic [7:0] cmd_addr_i;
   logic [7:0] cmd_data_i;
   logic       rsp_valid_o;
   logic       rsp_ready_i;
   logic [7:0] rsp_data_o;
   logic       rsp_err_o;
   logic [7:0] address_o;
   logic [7:0] data_o;
   logic       we_o;
   logic       strobe_o;
   logic [7:0] data_i;
   logic       ack_i;
   logic       busy_o;

   cmdT cmdQ [$];
   rspT rspQ [$];

   int assertCnt = 0;
   int failCnt   = 0;

   // Knobs the directed scenarios use to steer the slave and response sink.
   int         forceDelay = 0;     // 0 = random ack cycle
   logic       forceRdEn  = 1'b0;
   logic [7:0] forceRd    = 8'h00;
   int         readyMode  = 1;     // 0 = never, 1 = always, 2 = random

   usb_wb_initiator #(
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_we_i    (cmd_we_i),
      .cmd_addr_i  (cmd_addr_i),
      .cmd_data_i  (cmd_data_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_data_o  (rsp_data_o),
      .rsp_err_o   (rsp_err_o),
      .address_o   (address_o),
      .data_o      (data_o),
      .we_o        (we_o),
      .strobe_o    (strobe_o),
      .data_i      (data_i),
      .ack_i       (ack_i),
      .busy_o      (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertCnt++;
      if (act !== exp) begin
         failCnt++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Present one command from a negedge and record it once accepted.
   task automatic pushCmd(input logic we, input logic [7:0] addr, input logic [7:0] data);
      int waitCnt;
      waitCnt     = 0;
      cmd_valid_i = 1'b1;
      cmd_we_i    = we;
      cmd_addr_i  = addr;
      cmd_data_i  = data;
      while (!cmd_ready_o && waitCnt < 200) begin
         @(negedge clk);
         waitCnt++;
      end
      check("cmd_accept_bound", 32'(cmd_ready_o), 32'd1);
      if (cmd_ready_o) cmdQ.push_back('{we, addr, data});
      @(negedge clk);
      cmd_valid_i = 1'b0;
   endtask

   // Wait until everything issued has been executed and answered.
   task automatic waitIdle();
      int n;
      n = 0;
      while ((cmdQ.size() != 0 || rspQ.size() != 0 || busy_o || rsp_valid_o) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("drain_bound", 32'(n < 1000), 32'd1);
   endtask

   // Wishbone slave model: picks an ack cycle per transaction and predicts the response.
   initial begin : slaveProc
      logic       inBus;
      int         strobeCnt;
      int         ackAt;
      int         expLen;
      cmdT        curCmd;
      logic [7:0] rdData;
      inBus     = 1'b0;
      strobeCnt = 0;
      ackAt     = 0;
      expLen    = 0;
      rdData    = 8'h00;
      curCmd    = '{1'b0, 8'h00, 8'h00};
      ack_i     = 1'b0;
      data_i    = 8'h00;
      forever begin
         @(negedge clk);
         if (rst_i) begin
            inBus = 1'b0;
            ack_i = 1'b0;
         end else if (strobe_o) begin
            if (!inBus) begin
               inBus     = 1'b1;
               strobeCnt = 0;
               check("strobe_has_cmd", 32'(cmdQ.size() != 0), 32'd1);
               if (cmdQ.size() != 0) curCmd = cmdQ.pop_front();
               ackAt  = (forceDelay != 0) ? forceDelay : int'($urandom_range(1, TMO + 2));
               rdData = forceRdEn ? forceRd : 8'($urandom);
               expLen = (ackAt <= TMO) ? ackAt : TMO;
               if (ackAt <= TMO) rspQ.push_back('{1'b0, curCmd.we ? 8'h00 : rdData});
               else              rspQ.push_back('{1'b1, 8'h00});
            end
            check("bus_addr", 32'(address_o), 32'(curCmd.addr));
            check("bus_data", 32'(data_o), 32'(curCmd.data));
            check("bus_we", 32'(we_o), 32'(curCmd.we));
            strobeCnt++;
            ack_i  = (strobeCnt == ackAt);
            data_i = ack_i ? rdData : 8'($urandom);
         end else begin
            if (inBus) begin
               check("strobe_len", 32'(strobeCnt), 32'(expLen));
               check("rsp_valid_after_term", 32'(rsp_valid_o), 32'd1);
               inBus = 1'b0;
            end
            // Stray acks outside a bus cycle must be ignored by the DUT.
            ack_i  = ($urandom_range(0, 7) == 0);
            data_i = 8'($urandom);
         end
      end
   end

   // Response sink and monitor: chooses rsp_ready_i and compares against the scoreboard.
   initial begin : rspProc
      logic newReady;
      rsp_ready_i = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_i) begin
            rsp_ready_i = 1'b0;
         end else begin
            case (readyMode)
               0:       newReady = 1'b0;
               1:       newReady = 1'b1;
               default: newReady = ($urandom_range(0, 2) != 0);
            endcase
            rsp_ready_i = newReady;
            if (rsp_valid_o) begin
               check("no_strobe_in_resp", 32'(strobe_o), 32'd0);
               check("rsp_expected", 32'(rspQ.size() != 0), 32'd1);
               if (rspQ.size() != 0) begin
                  check("rsp_err", 32'(rsp_err_o), 32'(rspQ[0].err));
                  check("rsp_data", 32'(rsp_data_o), 32'(rspQ[0].data));
                  if (newReady) void'(rspQ.pop_front());
               end
            end
         end
      end
   end

   // Main sequence: directed scenarios, then a randomized run.
   initial begin : mainProc
      rst_i       = 1'b1;
      cmd_valid_i = 1'b0;
      cmd_we_i    = 1'b0;
      cmd_addr_i  = 8'h00;
      cmd_data_i  = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_strobe", 32'(strobe_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_ready", 32'(cmd_ready_o), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("rst_addr", 32'(address_o), 32'd0);
      #2 rst_i = 1'b0;
      @(negedge clk);

      // Write 0x5A to 0x03, acked on the second strobe cycle; check launch latency.
      forceDelay = 2;
      pushCmd(1'b1, 8'h03, 8'h5A);
      check("lat_strobe_low", 32'(strobe_o), 32'd0);
      check("lat_busy", 32'(busy_o), 32'd1);
      @(negedge clk);
      check("lat_strobe_high", 32'(strobe_o), 32'd1);
      waitIdle();

      // Read 0x10 returning 0xC3.
      forceDelay = 3;
      forceRdEn  = 1'b1;
      forceRd    = 8'hC3;
      pushCmd(1'b0, 8'h10, 8'h00);
      waitIdle();

      // Slave never acks: eight strobe cycles then an error response.
      forceDelay = 20;
      forceRdEn  = 1'b0;
      pushCmd(1'b0, 8'h22, 8'h00);
      waitIdle();

      // Stall a read response, fill the FIFO behind it, then release.
      readyMode  = 0;
      forceDelay = 1;
      forceRdEn  = 1'b1;
      forceRd    = 8'h77;
      pushCmd(1'b0, 8'h40, 8'h00);
      begin
         int n;
         n = 0;
         while (!rsp_valid_o && n < 50) begin
            @(negedge clk);
            n++;
         end
         check("stall_rsp_bound", 32'(rsp_valid_o), 32'd1);
      end
      forceDelay = 0;
      forceRdEn  = 1'b0;
      for (int i = 0; i < DEPTH; i++) pushCmd(1'(i & 1), 8'(8'h50 + i), 8'(8'hA0 + i));
      check("fifo_full_ready", 32'(cmd_ready_o), 32'd0);
      repeat (6) begin
         @(negedge clk);
         check("stall_no_strobe", 32'(strobe_o), 32'd0);
      end
      fork
         pushCmd(1'b1, 8'h5F, 8'hEE);
         begin
            @(posedge clk);
            readyMode = 1;
            @(negedge clk);
            @(negedge clk);
            check("release_idle_strobe", 32'(strobe_o), 32'd0);
            check("release_rsp_cleared", 32'(rsp_valid_o), 32'd0);
            @(negedge clk);
            check("release_next_strobe", 32'(strobe_o), 32'd1);
         end
      join
      waitIdle();

      // Reset mid-bus with two commands queued behind.
      forceDelay = 20;
      pushCmd(1'b0, 8'h61, 8'h00);
      pushCmd(1'b1, 8'h62, 8'h11);
      pushCmd(1'b1, 8'h63, 8'h22);
      @(negedge clk);
      check("pre_rst_strobe", 32'(strobe_o), 32'd1);
      #2 rst_i = 1'b1;
      #1;
      check("midrst_strobe", 32'(strobe_o), 32'd0);
      check("midrst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("midrst_busy", 32'(busy_o), 32'd0);
      check("midrst_ready", 32'(cmd_ready_o), 32'd1);
      check("midrst_we", 32'(we_o), 32'd0);
      check("midrst_data", 32'(data_o), 32'd0);
      cmdQ.delete();
      rspQ.delete();
      repeat (2) @(negedge clk);
      #2 rst_i = 1'b0;
      forceDelay = 0;
      repeat (4) @(negedge clk);
      check("postrst_busy", 32'(busy_o), 32'd0);
      check("postrst_rsp_valid", 32'(rsp_valid_o), 32'd0);

      // Randomized traffic with random response back-pressure.
      readyMode = 2;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         pushCmd(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      end
      waitIdle();
      check("final_cmdq_empty", 32'(cmdQ.size()), 32'd0);
      check("final_rspq_empty", 32'(rspQ.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin : watchdog
      #500000;
      failCnt++;
      $display("FAIL watchdog: run did not complete, time=%0t required=<500000", $time);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
      $finish;
   end

endmodule
